// File: rtl/led_pkg.sv
// Shared constants for the LED mode-select block.
// State encoding, LED width and default timing keyed to the 2400 Hz LED clock.
package led_pkg;

   localparam logic [1:0] RUN   = 2'd0;
   localparam logic [1:0] BLANK = 2'd1;
   localparam logic [1:0] OFF   = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN   = RUN,
      ST_BLANK = BLANK,
      ST_OFF   = OFF
   } state_t;

   localparam int LED_W = 8;

   localparam int CLK_HZ = 2400;

   localparam int DEF_NUM_MODES = 5;
   // 20 ms
   localparam int DEF_DEBOUNCE  = CLK_HZ / 50;
   // 2 s
   localparam int DEF_LONG      = CLK_HZ * 2;
   // 100 ms
   localparam int DEF_BLANK     = CLK_HZ / 10;

endpackage

// File: rtl/led_mode_mux_key_debounce.sv
// Key input path: 2-flop sync, debounce, hold timer, short/long press events.
// Ports: clk, rst_n, key_n (raw, active-low) -> short_ev, long_ev (1-cycle).
module key_debounce
   import led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE,
   parameter int LONG_PRESS_CYCLES = DEF_LONG
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic short_ev,
   output logic long_ev
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

   logic          sync1;
   logic          sync2;
   logic          key_stable;
   logic          stable_q;
   logic          long_done;
   logic [DW-1:0] deb_cnt;
   logic [HW-1:0] hold_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive
   // differing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_stable <= 1'b1;
         deb_cnt    <= '0;
      end else if (sync2 == key_stable) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
         key_stable <= sync2;
         deb_cnt    <= '0;
      end else begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q  <= 1'b1;
         hold_cnt  <= '0;
         long_done <= 1'b0;
      end else begin
         stable_q <= key_stable;
         if (key_stable) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
         end else begin
            if (hold_cnt != HW'(LONG_PRESS_CYCLES))
               hold_cnt <= hold_cnt + HW'(1);
            if (long_ev)
               long_done <= 1'b1;
         end
      end
   end

   // long_done still reflects the finished press in the release
   // cycle, which suppresses the short event after a long press.
   assign long_ev  = !key_stable &&
                     (hold_cnt == HW'(LONG_PRESS_CYCLES)) &&
                     !long_done;
   assign short_ev = key_stable && !stable_q && !long_done;

endmodule

// File: rtl/led_mode_mux.sv
// LED output select: mode FSM (RUN/BLANK/OFF), blank timer, pattern mux.
// Ports: clk, rst_n, key_n, led_in -> led_out, mode, mode_rst_n, mode_changed.
module led_mode_mux
   import led_pkg::*;
#(
   parameter int NUM_MODES         = DEF_NUM_MODES,
   parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE,
   parameter int LONG_PRESS_CYCLES = DEF_LONG,
   parameter int BLANK_CYCLES      = DEF_BLANK
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       key_n,
   input  logic [LED_W*NUM_MODES-1:0] led_in,
   output logic [LED_W-1:0]           led_out,
   output logic [2:0]                 mode,
   output logic [NUM_MODES-1:0]       mode_rst_n,
   output logic                       mode_changed
);

   localparam int BW = $clog2(BLANK_CYCLES + 1);

   logic          short_ev;
   logic          long_ev;
   state_t        state;
   state_t        state_nx;
   logic [2:0]    mode_nx;
   logic [2:0]    mode_inc;
   logic [BW-1:0] blank_cnt;
   logic [BW-1:0] blank_nx;
   logic          enter_blank;
   logic [LED_W-1:0] led_sel;
   logic [LED_W-1:0] led_nx;

   key_debounce #(
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
   ) u_key (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_n    (key_n),
      .short_ev (short_ev),
      .long_ev  (long_ev)
   );

   always_comb begin
      if (mode == 3'(NUM_MODES - 1))
         mode_inc = 3'd0;
      else
         mode_inc = mode + 3'd1;
   end

   always_comb begin
      state_nx    = state;
      mode_nx     = mode;
      blank_nx    = blank_cnt;
      enter_blank = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (long_ev) begin
               state_nx = ST_OFF;
            end else if (short_ev) begin
               mode_nx     = mode_inc;
               state_nx    = ST_BLANK;
               blank_nx    = '0;
               enter_blank = 1'b1;
            end
         end
         ST_BLANK: begin
            if (long_ev) begin
               state_nx = ST_OFF;
               blank_nx = '0;
            end else if (short_ev) begin
               mode_nx     = mode_inc;
               blank_nx    = '0;
               enter_blank = 1'b1;
            end else if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
               state_nx = ST_RUN;
               blank_nx = '0;
            end else begin
               blank_nx = blank_cnt + BW'(1);
            end
         end
         ST_OFF: begin
            // wake-up keeps the mode it was put to sleep in
            if (short_ev) begin
               state_nx    = ST_BLANK;
               blank_nx    = '0;
               enter_blank = 1'b1;
            end
         end
         default: begin
            state_nx = ST_RUN;
         end
      endcase
   end

   // Select on the next mode so led_out is a plain register
   // with one cycle of latency from led_in.
   always_comb begin
      led_sel = '0;
      for (int k = 0; k < NUM_MODES; k++) begin
         if (mode_nx == 3'(k))
            led_sel = led_in[LED_W*k +: LED_W];
      end
      led_nx = (state_nx == ST_RUN) ? led_sel : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_RUN;
         mode         <= 3'd0;
         blank_cnt    <= '0;
         led_out      <= '0;
         mode_rst_n   <= '1;
         mode_changed <= 1'b0;
      end else begin
         state        <= state_nx;
         mode         <= mode_nx;
         blank_cnt    <= blank_nx;
         led_out      <= led_nx;
         mode_changed <= enter_blank;
         if (enter_blank)
            mode_rst_n <= ~(NUM_MODES'(1) << mode_nx);
         else
            mode_rst_n <= '1;
      end
   end

endmodule
